// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: widths, FSM states and
// the buffer entry layout.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        KILL
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response handshake between the fetch sequencer
// (master) and the instruction memory (slave).
interface fetch_ctrl_if;

    logic                       imem_req;
    logic [fetch_pkg::XLEN-1:0] imem_addr;
    logic                       imem_gnt;
    logic                       imem_rvalid;
    logic [fetch_pkg::ILEN-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/fetch_buf.sv
// Flushable FIFO of fetched {pc, instr} entries with wrap-around pointers.
// Push and pop may coincide at any occupancy; flush empties it in one edge.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the head is only observed
    // through the empty flag, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one outstanding imem fetch at a
// time under a buffer-credit rule, and handles redirect flush/kill.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    fetch_ctrl_if.master      imem,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              hold,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [ILEN-1:0]   out_instr
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            push;
    logic            pop;
    logic            req;
    logic            fire;
    logic            inflight;
    logic            credit;
    logic [CW-1:0]   count;
    logic            buf_empty;
    logic            buf_full;
    fetch_entry_t    head;

    // One request outstanding at most, so anything past FETCH is in flight.
    assign inflight = (state_q != FETCH);
    assign credit   = ~buf_full & ((int'(count) + int'(inflight)) < BUF_DEPTH);
    assign req      = (state_q == FETCH) & credit & ~rst;
    assign fire     = req & imem.imem_gnt;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        case (state_q)
            FETCH: if (fire) begin
                pc_d     = pc_q + PC_STEP;
                req_pc_d = pc_q;
                state_d  = WAIT;
            end
            WAIT: if (imem.imem_rvalid) begin
                push    = 1'b1;
                state_d = FETCH;
            end
            KILL: if (imem.imem_rvalid) state_d = FETCH;
            default: state_d = FETCH;
        endcase

        // A redirect overrides everything; a granted or pending response
        // becomes stale and must be swallowed in KILL.
        if (redirect) begin
            pc_d = align_pc(redirect_pc);
            push = 1'b0;
            if (state_q == FETCH) state_d = fire ? KILL : FETCH;
            else                  state_d = imem.imem_rvalid ? FETCH : KILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign out_valid = ~buf_empty;
    assign pop       = out_valid & ~hold;
    assign out_pc    = buf_empty ? '0 : head.pc;
    assign out_instr = buf_empty ? '0 : head.instr;

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ('{pc: req_pc_q, instr: imem.imem_rdata}),
        .rdata (head),
        .count (count),
        .empty (buf_empty),
        .full  (buf_full)
    );

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer that owns the program counter and issues word fetches to the instruction memory over a req/gnt/rvalid handshake. Returned instructions go into a small flushable buffer. The buffer presents pc/instr/valid to the fetch latch and honours the downstream hold. Redirects from execute (branch/jump) flush the buffer and kill any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUF_DEPTH, 2, instruction buffer entries; power of two, >=2

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word aligned ([1:0]=0)
imem_gnt  in  1  memory accepts request this cycle (sampled only when imem_req=1)
imem_rvalid  in  1  read data valid for oldest accepted request
imem_rdata  in  32  instruction word
redirect  in  1  single-cycle PC redirect pulse
redirect_pc  in  32  new PC; bits [1:0] ignored (forced 0)
hold  in  1  downstream stall; buffer head not consumed while high
out_valid  out  1  buffer head valid
out_pc  out  32  PC of buffer head
out_instr  out  32  instruction of buffer head

Behaviour:
- Reset (async, any time, including mid-transaction): pc=RESET_PC, state=FETCH, buffer empty, inflight=0. imem_req=0 while rst=1. out_valid=0, out_pc=0, out_instr=0. Any rvalid arriving after reset release for a pre-reset request is the memory's problem: the memory is reset together with this block.
- Max one outstanding request. Credit rule: request only when occupancy + inflight < BUF_DEPTH.
- States:
  - FETCH: imem_req = credit available; imem_addr=pc. On req&gnt: pc<=pc+4, inflight=1, go WAIT.
  - WAIT: imem_req=0. On rvalid: push {pc_of_req, rdata}, inflight=0, go FETCH.
  - KILL: imem_req=0. On rvalid: discard, inflight=0, go FETCH.
- pc_of_req is captured at grant.
- Memory samples only on req&gnt, so imem_addr may change before grant (e.g. on redirect).
- Redirect (highest priority, takes effect same edge):
  - pc<=redirect_pc & ~3; buffer flushed; any push this cycle is suppressed.
  - From FETCH with gnt same cycle: go KILL (the granted address is stale).
  - From FETCH without gnt: stay FETCH.
  - From WAIT: go KILL unless rvalid same cycle, in which case the data is discarded and state goes FETCH.
  - From KILL: stay KILL, or go FETCH if rvalid same cycle.
- First fetch after a redirect can be requested the following cycle: imem_req=1, addr=new pc.
- Buffer: FIFO with wrap-around pointers.
  - out_valid = !empty; pop when out_valid & ~hold.
  - Simultaneous push and pop allowed at any occupancy, including full (pop frees the slot).
  - The credit rule guarantees no push when full without a pop; the bench asserts this.
  - out_pc/out_instr stable while out_valid & hold.
  - Empty with push: data visible next cycle (1-cycle rvalid-to-out_valid latency).
  - Flush: out_valid=0 next cycle.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- Best-case throughput: one instruction every 2 cycles per outstanding slot (gnt then rvalid).

Decomposition:
- Package fetch_pkg:
  - XLEN=32
  - ILEN=32
  - fetch_state_t enum {FETCH, WAIT, KILL}
  - PC_STEP=4
  - fetch_entry_t struct {pc, instr}
- Sub-module fetch_buf:
  - Parameterised FIFO of fetch_entry_t with push, pop, flush, count, empty, full.
  - Async-reset to empty.
- fetch_ctrl keeps the FSM, pc, inflight, credit and redirect logic.

Test Plan:
- Reset release, gnt=1 every cycle, rvalid one cycle after each gnt, hold=0 -> imem_addr sequence 0,4,8,...; out_pc 0,4,8 with matching rdata; out_valid first high 3 cycles after reset release.
- hold=1 held after two fills (BUF_DEPTH=2) -> imem_req stays 0, out_pc stays 0, instr unchanged. Release hold -> pops 0 then 4, and fetch resumes at 8.
- redirect to 32'h0000_0103 while in WAIT -> state KILL; next rvalid discarded; next imem_addr=32'h0000_0100; buffer empty; first out_pc after recovery=0x100.
- redirect coinciding with gnt in FETCH -> granted response dropped; next request addr=redirect_pc; no stale out_pc ever appears.
- redirect same cycle as rvalid in WAIT -> data dropped, state FETCH; imem_req=1 next cycle at redirect_pc.
- rst asserted mid-WAIT with buffer holding 1 entry -> out_valid=0 immediately (async); after release imem_addr=RESET_PC. Separately, pc at 32'hFFFF_FFFC -> next fetch addr 32'h0000_0000.
